// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with req/ack data memory, load formatting and MEM_WB register.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_EX_MEM,
  input  logic [31:0] ALU_Result_EX_MEM,
  input  logic [31:0] write_data_EX_MEM,
  input  logic        MemRead_EX_MEM,
  input  logic        MemWrite_EX_MEM,
  input  logic [1:0]  MemSize_EX_MEM,
  input  logic        MemSigned_EX_MEM,
  input  logic [1:0]  MemtoReg_EX_MEM,
  input  logic        RegWrite_EX_MEM,
  input  logic [4:0]  write_reg_EX_MEM,
  input  logic [31:0] pc_EX_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_MEM,
  output logic        mem_err,
  output logic [31:0] read_data_MEM_WB,
  output logic [31:0] ALU_Result_MEM_WB,
  output logic [1:0]  MemtoReg_MEM_WB,
  output logic        RegWrite_MEM_WB,
  output logic [4:0]  write_reg_MEM_WB,
  output logic [31:0] pc_MEM_WB
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [1:0] a;
  logic [31:0] sh, fmt;
  logic mem_op, mis, req, hit, stall, abort, is_load;
  assign a = ALU_Result_EX_MEM[1:0];
  assign mem_op = valid_EX_MEM & (MemRead_EX_MEM | MemWrite_EX_MEM);
  assign is_load = MemRead_EX_MEM & ~MemWrite_EX_MEM;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = mem_op & (MemSize_EX_MEM == 2'b01 ? a[0] : MemSize_EX_MEM[1] & (a != 2'b00));
`else
  assign mis = 1'b0;
`endif
  // Gated by reset_n so the bus and stall are quiet while reset is held
  assign req = mem_op & ~mis & reset_n;
  assign hit = (state == WAIT) & req & ~dmem_ack & (cnt == 8'(DMEM_TIMEOUT));
  assign stall = req & ~dmem_ack & ~hit;
  assign abort = hit | mis;
  assign dmem_req = req;
  assign dmem_we = req & MemWrite_EX_MEM;
  assign stall_MEM = stall;
  assign dmem_addr = {ALU_Result_EX_MEM[31:2], 2'b00};
  always_comb begin
    dmem_be = MemSize_EX_MEM == 2'b00 ? 4'b0001 << a :
              MemSize_EX_MEM == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    dmem_wdata = MemSize_EX_MEM == 2'b00 ? {4{write_data_EX_MEM[7:0]}} :
                 MemSize_EX_MEM == 2'b01 ? {2{write_data_EX_MEM[15:0]}} : write_data_EX_MEM;
    sh = dmem_rdata >> (MemSize_EX_MEM == 2'b00 ? {a, 3'b000} :
                        MemSize_EX_MEM == 2'b01 ? {a[1], 4'b0000} : 5'd0);
    fmt = MemSize_EX_MEM == 2'b00 ? {{24{MemSigned_EX_MEM & sh[7]}}, sh[7:0]} :
          MemSize_EX_MEM == 2'b01 ? {{16{MemSigned_EX_MEM & sh[15]}}, sh[15:0]} : dmem_rdata;
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    if (state == IDLE) begin
      state_d = (req & ~dmem_ack) ? WAIT : IDLE;
      cnt_d = (req & ~dmem_ack) ? 8'd1 : 8'd0;
    end else begin
      state_d = stall ? WAIT : IDLE;
      cnt_d = stall ? cnt + 8'd1 : 8'd0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      mem_err <= 1'b0;
      read_data_MEM_WB <= 32'd0;
      ALU_Result_MEM_WB <= 32'd0;
      MemtoReg_MEM_WB <= 2'd0;
      RegWrite_MEM_WB <= 1'b0;
      write_reg_MEM_WB <= 5'd0;
      pc_MEM_WB <= 32'd0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      mem_err <= abort;
      if (!valid_EX_MEM || stall) begin
        RegWrite_MEM_WB <= 1'b0;
      end else begin
        read_data_MEM_WB <= (is_load & mem_op & ~abort) ? fmt : 32'd0;
        ALU_Result_MEM_WB <= ALU_Result_EX_MEM;
        MemtoReg_MEM_WB <= MemtoReg_EX_MEM;
        RegWrite_MEM_WB <= RegWrite_EX_MEM & ~abort;
        write_reg_MEM_WB <= write_reg_EX_MEM;
        pc_MEM_WB <= pc_EX_MEM;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with DMEM_TIMEOUT = 4.
module tb_mem_stage;
  logic clk = 1'b0, reset_n = 1'b0;
  logic valid, mr, mw, sg, rw, ack;
  logic [1:0] sz, m2r;
  logic [4:0] wreg;
  logic [31:0] alu, wd, pc, rdat;
  logic dmem_req, dmem_we, stall_MEM, mem_err, RegWrite_MEM_WB;
  logic [31:0] dmem_addr, dmem_wdata, read_data_MEM_WB, ALU_Result_MEM_WB, pc_MEM_WB;
  logic [3:0] dmem_be;
  logic [1:0] MemtoReg_MEM_WB;
  logic [4:0] write_reg_MEM_WB;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [31:0] rd, alu, pc;
    logic [1:0] m2r;
    logic rw;
    logic [4:0] wr;
    logic err;
  } exp_t;
  exp_t q[$];

  mem_stage #(.DMEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_EX_MEM(valid), .ALU_Result_EX_MEM(alu),
    .write_data_EX_MEM(wd), .MemRead_EX_MEM(mr), .MemWrite_EX_MEM(mw),
    .MemSize_EX_MEM(sz), .MemSigned_EX_MEM(sg), .MemtoReg_EX_MEM(m2r),
    .RegWrite_EX_MEM(rw), .write_reg_EX_MEM(wreg), .pc_EX_MEM(pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(rdat), .dmem_ack(ack),
    .stall_MEM(stall_MEM), .mem_err(mem_err), .read_data_MEM_WB(read_data_MEM_WB),
    .ALU_Result_MEM_WB(ALU_Result_MEM_WB), .MemtoReg_MEM_WB(MemtoReg_MEM_WB),
    .RegWrite_MEM_WB(RegWrite_MEM_WB), .write_reg_MEM_WB(write_reg_MEM_WB),
    .pc_MEM_WB(pc_MEM_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic [1:0] s,
                       input logic sgn, input logic [31:0] ad, input logic [31:0] d,
                       input logic [1:0] mt, input logic rwr, input logic [4:0] wr,
                       input logic [31:0] p, input logic [31:0] rdd, input logic ak);
    valid = v; mr = r; mw = w; sz = s; sg = sgn; alu = ad; wd = d;
    m2r = mt; rw = rwr; wreg = wr; pc = p; rdat = rdd; ack = ak;
  endtask

  task automatic push(input logic [31:0] rd, input logic [31:0] ad, input logic [1:0] mt,
                      input logic rwr, input logic [4:0] wr, input logic [31:0] p, input logic e);
    exp_t x;
    x.rd = rd; x.alu = ad; x.m2r = mt; x.rw = rwr; x.wr = wr; x.pc = p; x.err = e;
    q.push_back(x);
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 0, 32'd0, 32'd0, 2'b00, 0, 5'd0, 32'd0, 32'd0, 0);
  endtask

  initial begin
    idle();
    fork
      forever begin
        logic r;
        exp_t e;
        @(negedge clk);
        #2;
        r = reset_n & valid & ~stall_MEM;
        @(posedge clk);
        #1;
        if (r) begin
          if (q.size() == 0) begin
            chk("retire_unexpected", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("wb_read_data", read_data_MEM_WB, e.rd);
            chk("wb_alu", ALU_Result_MEM_WB, e.alu);
            chk("wb_memtoreg", {30'd0, MemtoReg_MEM_WB}, {30'd0, e.m2r});
            chk("wb_regwrite", {31'd0, RegWrite_MEM_WB}, {31'd0, e.rw});
            chk("wb_write_reg", {27'd0, write_reg_MEM_WB}, {27'd0, e.wr});
            chk("wb_pc", pc_MEM_WB, e.pc);
            chk("wb_mem_err", {31'd0, mem_err}, {31'd0, e.err});
          end
        end else begin
          chk("bubble_regwrite", {31'd0, RegWrite_MEM_WB}, 32'd0);
          chk("bubble_mem_err", {31'd0, mem_err}, 32'd0);
        end
      end
    join_none
    #1;
    chk("rst_regwrite", {31'd0, RegWrite_MEM_WB}, 32'd0);
    chk("rst_read_data", read_data_MEM_WB, 32'd0);
    chk("rst_pc", pc_MEM_WB, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // word load, zero-wait
    drive(1, 1, 0, 2'b10, 0, 32'h100, 32'd0, 2'b01, 1, 5'd5, 32'h40, 32'hDEADBEEF, 1);
    push(32'hDEADBEEF, 32'h100, 2'b01, 1, 5'd5, 32'h40, 0);
    #1;
    chk("t1_stall", {31'd0, stall_MEM}, 32'd0);
    chk("t1_req", {31'd0, dmem_req}, 32'd1);
    chk("t1_we", {31'd0, dmem_we}, 32'd0);
    chk("t1_addr", dmem_addr, 32'h100);
    chk("t1_be", {28'd0, dmem_be}, 32'hF);
    // signed byte load, ack after 3 wait cycles
    @(negedge clk);
    drive(1, 1, 0, 2'b00, 1, 32'h103, 32'd0, 2'b01, 1, 5'd6, 32'h44, 32'h80112233, 0);
    push(32'hFFFFFF80, 32'h103, 2'b01, 1, 5'd6, 32'h44, 0);
    #1;
    chk("t2_stall0", {31'd0, stall_MEM}, 32'd1);
    chk("t2_be", {28'd0, dmem_be}, 32'h8);
    chk("t2_addr", dmem_addr, 32'h100);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("t2_stall", {31'd0, stall_MEM}, 32'd1);
    end
    @(negedge clk);
    ack = 1'b1;
    #1;
    chk("t2_stall_ack", {31'd0, stall_MEM}, 32'd0);
    // half store
    @(negedge clk);
    drive(1, 0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 2'b00, 0, 5'd0, 32'h48, 32'd0, 1);
    push(32'd0, 32'h202, 2'b00, 0, 5'd0, 32'h48, 0);
    #1;
    chk("t3_be", {28'd0, dmem_be}, 32'hC);
    chk("t3_wdata", dmem_wdata, 32'hABCDABCD);
    chk("t3_we", {31'd0, dmem_we}, 32'd1);
    chk("t3_addr", dmem_addr, 32'h200);
    // byte store
    @(negedge clk);
    drive(1, 0, 1, 2'b00, 0, 32'h301, 32'h12345677, 2'b00, 0, 5'd0, 32'h4C, 32'd0, 1);
    push(32'd0, 32'h301, 2'b00, 0, 5'd0, 32'h4C, 0);
    #1;
    chk("t3b_be", {28'd0, dmem_be}, 32'h2);
    chk("t3b_wdata", dmem_wdata, 32'h77777777);
    // unsigned upper-half load
    @(negedge clk);
    drive(1, 1, 0, 2'b01, 0, 32'h102, 32'd0, 2'b01, 1, 5'd8, 32'h50, 32'h80011234, 1);
    push(32'h00008001, 32'h102, 2'b01, 1, 5'd8, 32'h50, 0);
    #1;
    chk("t3c_be", {28'd0, dmem_be}, 32'hC);
    // timeout abort
    @(negedge clk);
    drive(1, 1, 0, 2'b10, 0, 32'h400, 32'd0, 2'b01, 1, 5'd7, 32'h54, 32'd0, 0);
    push(32'd0, 32'h400, 2'b01, 0, 5'd7, 32'h54, 1);
    #1;
    chk("t4_stall0", {31'd0, stall_MEM}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t4_stall", {31'd0, stall_MEM}, 32'd1);
    end
    @(negedge clk);
    #1;
    chk("t4_stall_hit", {31'd0, stall_MEM}, 32'd0);
    chk("t4_err_early", {31'd0, mem_err}, 32'd0);
    // ALU pass-through
    @(negedge clk);
    drive(1, 0, 0, 2'b00, 0, 32'h0000000A, 32'd0, 2'b00, 1, 5'd1, 32'h58, 32'd0, 0);
    push(32'd0, 32'hA, 2'b00, 1, 5'd1, 32'h58, 0);
    #1;
    chk("t4_err_pulse", {31'd0, mem_err}, 32'd1);
    chk("t5_req", {31'd0, dmem_req}, 32'd0);
    chk("t5_stall", {31'd0, stall_MEM}, 32'd0);
    // stray ack with no memory op
    @(negedge clk);
    idle();
    ack = 1'b1;
    #1;
    chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_ack_stall", {31'd0, stall_MEM}, 32'd0);
    // reset while waiting
    @(negedge clk);
    drive(1, 1, 0, 2'b10, 0, 32'h500, 32'd0, 2'b01, 1, 5'd3, 32'h5C, 32'd0, 0);
    #1;
    chk("t6_stall0", {31'd0, stall_MEM}, 32'd1);
    @(negedge clk);
    #1;
    chk("t6_stall1", {31'd0, stall_MEM}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_pc", pc_MEM_WB, 32'd0);
    chk("t6_rst_alu", ALU_Result_MEM_WB, 32'd0);
    chk("t6_rst_regwrite", {31'd0, RegWrite_MEM_WB}, 32'd0);
    chk("t6_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("t6_rst_stall", {31'd0, stall_MEM}, 32'd0);
    chk("t6_rst_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 1, 0, 2'b10, 1, 32'h600, 32'd0, 2'b01, 1, 5'd9, 32'h60, 32'h11223344, 1);
    push(32'h11223344, 32'h600, 2'b01, 1, 5'd9, 32'h60, 0);
    #1;
    chk("t6_fresh_stall", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk);
    drive(1, 1, 0, 2'b10, 0, 32'h604, 32'd0, 2'b01, 1, 5'd10, 32'h64, 32'hCAFEF00D, 0);
    push(32'hCAFEF00D, 32'h604, 2'b01, 1, 5'd10, 32'h64, 0);
    #1;
    chk("t6_wait_stall", {31'd0, stall_MEM}, 32'd1);
    @(negedge clk);
    ack = 1'b1;
    #1;
    chk("t6_wait_ack", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline MEM stage, directly upstream of the WB stage; owns the MEM_WB pipeline register.
- Takes EX_MEM results and performs data-memory loads and stores over a req/ack handshake.
- Formats load data: byte/half/word, signed or unsigned.
- Holds the pipeline with stall_MEM while memory is busy, then registers everything the WB stage consumes.

Parameters:
DMEM_TIMEOUT, 255, cycles waiting for dmem_ack before the access is aborted; range 1..255, 8-bit counter.

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
valid_EX_MEM  input  1  EX_MEM holds a real instruction
ALU_Result_EX_MEM  input  32  memory address, or ALU result for non-memory ops
write_data_EX_MEM  input  32  store data, right-aligned
MemRead_EX_MEM  input  1  load
MemWrite_EX_MEM  input  1  store
MemSize_EX_MEM  input  2  00 byte, 01 half, 10 word, 11 treated as word
MemSigned_EX_MEM  input  1  sign-extend loads
MemtoReg_EX_MEM  input  2  passed to WB
RegWrite_EX_MEM  input  1  passed to WB
write_reg_EX_MEM  input  5  passed to WB
pc_EX_MEM  input  32  passed to WB
dmem_req  output  1  access request
dmem_we  output  1  1 = store
dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_rdata  input  32  load data, valid when dmem_ack=1
dmem_ack  input  1  access complete this cycle
stall_MEM  output  1  upstream must hold EX_MEM and earlier stages
mem_err  output  1  one-cycle pulse on timeout abort
read_data_MEM_WB  output  32  formatted load data
ALU_Result_MEM_WB  output  32
MemtoReg_MEM_WB  output  2
RegWrite_MEM_WB  output  1
write_reg_MEM_WB  output  5
pc_MEM_WB  output  32

Behaviour:
- Reset: asynchronous on reset_n low. All MEM_WB outputs 0, mem_err 0, FSM IDLE, timeout counter 0. dmem_req and stall_MEM evaluate to 0 during reset.
- mem_op = valid_EX_MEM & (MemRead_EX_MEM | MemWrite_EX_MEM). If both Read and Write are set, Write takes priority.
- FSM states are IDLE and WAIT.
  - dmem_req = mem_op in either state.
  - stall_MEM = mem_op & ~dmem_ack & ~timeout_hit.
- IDLE:
  - mem_op with dmem_ack high: zero-wait access, no stall.
  - mem_op with dmem_ack low: go to WAIT, counter = 1.
- WAIT:
  - dmem_ack high: return to IDLE.
  - Otherwise counter increments; timeout_hit = (counter == DMEM_TIMEOUT).
  - On timeout_hit: abort, mem_err = 1 next cycle, return to IDLE.
- MEM_WB register update, every cycle:
  - Non-memory valid instruction: fields pass through.
  - Memory op: latch only on the ack or abort cycle. While stalled, insert a bubble: RegWrite_MEM_WB = 0; other fields don't-care but held.
  - Aborted op: RegWrite_MEM_WB = 0.
  - valid_EX_MEM = 0: bubble.
- Store lanes, with a = ALU_Result_EX_MEM[1:0]:
  - Byte: be = 0001 << a; wdata = byte replicated x4.
  - Half: be = 0011 << {a[1],0}; wdata = half replicated x2.
  - Word: be = 1111.
- Loads: rdata >> (8 × lane offset), then zero- or sign-extend to 32 per MemSigned_EX_MEM. Word loads are unchanged.
- read_data_MEM_WB = 0 for non-loads.
- An ack arriving while mem_op = 0 is ignored.
- Reset mid-WAIT: immediate return to IDLE, no mem_err.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined:
  - A half access with a[0]=1, or a word access with a≠0, is misaligned.
  - No dmem_req and no stall for a misaligned access.
  - It retires with RegWrite_MEM_WB = 0 and mem_err pulses.
- Undefined:
  - Low address bits are ignored as above: word forced aligned, half uses a[1].
  - No checking is performed.

Test Plan:
- Word load, addr 0x100, ack in the request cycle, rdata 0xDEADBEEF -> no stall; next cycle read_data_MEM_WB = 0xDEADBEEF, RegWrite_MEM_WB = 1.
- Signed byte load, addr 0x103, rdata 0x80112233, ack after 3 cycles -> stall_MEM high 3 cycles, 3 bubbles with RegWrite_MEM_WB = 0, then read_data_MEM_WB = 0xFFFFFF80.
- Half store, addr 0x202, data 0x0000ABCD -> dmem_be = 1100, dmem_wdata = 0xABCDABCD, dmem_we = 1, dmem_addr = 0x200.
- No ack, DMEM_TIMEOUT = 4 -> stall 4 cycles, mem_err pulses once, RegWrite_MEM_WB = 0, FSM back in IDLE.
- ALU op, ALU_Result 0x0000000A, write_reg 1, MemtoReg 00 -> passes through one cycle later; dmem_req stays 0.
- reset_n low during WAIT -> all outputs 0 immediately; after release, a fresh load completes normally.
